// File: rtl/ofm_writeback_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between the OFM writeback controller
// and the DDR interconnect.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. Once the source raises valid it keeps
// valid and its payload stable until that edge; ready may change freely and
// never has to wait for valid.
interface ofm_writeback_ctrl_if #(
    parameter int AXI_DATA_W = 128,
    parameter int AXI_ADDR_W = 32
);
    logic [AXI_ADDR_W-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [AXI_DATA_W-1:0]   m_wdata;
    logic [AXI_DATA_W/8-1:0] m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/ofm_writeback_ctrl.sv
// OFM writeback controller: streams packed OFM buffer words to DDR as AXI4
// INCR bursts that never cross a 4 KB page, with a partial strobe on the last
// beat of the transfer and sticky error reporting from write responses.
module ofm_writeback_ctrl #(
    parameter int DATA_W     = 16,
    parameter int AXI_DATA_W = 128,
    parameter int AXI_ADDR_W = 32,
    parameter int ADDR_W     = 10,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]       num_elems,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     buf_rd_addr,
    output logic                  buf_rd_en,
    input  logic [AXI_DATA_W-1:0] buf_rd_data,
    output logic [2:0]            dbg_state,
    ofm_writeback_ctrl_if.master  axi
);
    localparam int PF         = AXI_DATA_W / DATA_W;
    localparam int PF_LOG     = $clog2(PF);
    localparam int BEAT_BYTES = AXI_DATA_W / 8;
    localparam int BEAT_LOG   = $clog2(BEAT_BYTES);
    localparam int ELEM_BYTES = DATA_W / 8;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int CNTX_W     = CNT_W + 1;
    localparam int BEATS_W    = 9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [AXI_ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]      rem_q;
    logic [PF_LOG-1:0]     tail_q;
    logic [BEATS_W-1:0]    beats_q;
    logic [7:0]            awlen_q;
    logic [BEATS_W-1:0]    rd_left_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [7:0]            w_beat_q;
    logic                  error_q;

    logic                  in_flight_q;
    logic [1:0]            cnt_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [AXI_DATA_W-1:0] fifo_mem [2];

    logic [CNT_W-1:0]      words;
    logic [12:0]           room_beats;
    logic [12:0]           beats_calc;
    logic [2:0]            occupancy;
    logic                  rd_en;
    logic                  wvalid;
    logic                  wlast;
    logic                  pop;
    logic                  final_beat;
    logic [BEAT_BYTES-1:0] tail_strb;

    // Word count of the requested transfer, rounded up to whole beats.
    assign words = CNT_W'(({1'b0, num_elems} + CNTX_W'(PF - 1)) >> PF_LOG);

    // Size of the next burst: limited by remaining words, the burst cap and
    // the distance to the next 4 KB page boundary.
    always_comb begin
        room_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BEAT_LOG;
        beats_calc = 13'(rem_q);
        if (13'(MAX_BURST) < beats_calc) beats_calc = 13'(MAX_BURST);
        if (room_beats < beats_calc)     beats_calc = room_beats;
    end

    // Next-state logic of the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (num_elems == '0) ? S_FIN : S_CALC;
            S_CALC: state_d = S_AW;
            S_AW:   if (axi.m_awready) state_d = S_W;
            S_W:    if (pop && wlast) state_d = S_B;
            S_B:    if (axi.m_bvalid)
                        state_d = (rem_q != CNT_W'(beats_q)) ? S_CALC : S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Read issue: keep the skid FIFO plus the read in flight at two words at
    // most; a beat leaving this cycle frees a slot, which sustains one beat
    // per cycle once the FIFO is primed.
    always_comb begin
        occupancy = {1'b0, cnt_q} + {2'b00, in_flight_q};
        wvalid    = (state_q == S_W) && (cnt_q != 2'd0);
        pop       = wvalid && axi.m_wready;
        wlast     = (w_beat_q == awlen_q);
        rd_en     = (state_q == S_W) && (rd_left_q != '0) &&
                    ((occupancy < 3'd2) || pop);
    end

    // Strobe for the final beat: only the bytes of the trailing elements.
    always_comb begin
        final_beat = wlast && (rem_q == CNT_W'(beats_q)) && (tail_q != '0);
        for (int i = 0; i < BEAT_BYTES; i++) begin
            tail_strb[i] = (i < int'(tail_q) * ELEM_BYTES);
        end
    end

    // Transfer bookkeeping: address, remaining words, burst and read counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rem_q     <= '0;
            tail_q    <= '0;
            beats_q   <= '0;
            awlen_q   <= '0;
            rd_left_q <= '0;
            rd_addr_q <= '0;
            w_beat_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                addr_q    <= base_addr;
                rem_q     <= words;
                tail_q    <= num_elems[PF_LOG-1:0];
                rd_addr_q <= '0;
                error_q   <= 1'b0;
            end
            if (state_q == S_CALC) begin
                beats_q   <= beats_calc[BEATS_W-1:0];
                rd_left_q <= beats_calc[BEATS_W-1:0];
                awlen_q   <= 8'(beats_calc - 13'd1);
                w_beat_q  <= '0;
            end
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                rd_left_q <= rd_left_q - 1'b1;
            end
            if (pop) w_beat_q <= w_beat_q + 8'd1;
            if (state_q == S_B && axi.m_bvalid) begin
                error_q <= error_q | (axi.m_bresp != 2'b00);
                addr_q  <= addr_q + (AXI_ADDR_W'(beats_q) << BEAT_LOG);
                rem_q   <= rem_q - CNT_W'(beats_q);
            end
        end
    end

    // Two-entry skid FIFO fed by the buffer's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
            cnt_q       <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            in_flight_q <= rd_en;
            if (in_flight_q) begin
                fifo_mem[wr_ptr_q] <= buf_rd_data;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_AW) ||
                         (state_q == S_W)    || (state_q == S_B);
    assign done        = (state_q == S_FIN);
    assign error       = error_q;
    assign dbg_state   = state_q;
    assign buf_rd_addr = rd_addr_q;
    assign buf_rd_en   = rd_en;

    assign axi.m_awaddr  = addr_q;
    assign axi.m_awlen   = awlen_q;
    assign axi.m_awsize  = 3'(BEAT_LOG);
    assign axi.m_awburst = 2'b01;
    assign axi.m_awvalid = (state_q == S_AW);
    assign axi.m_wdata   = fifo_mem[rd_ptr_q];
    assign axi.m_wstrb   = final_beat ? tail_strb : '1;
    assign axi.m_wlast   = wlast;
    assign axi.m_wvalid  = wvalid;
    assign axi.m_bready  = (state_q == S_B);
endmodule
